// File: rtl/ifetch_buffer.sv
// Instruction fetch stage: owns the PC, reads the instruction ROM, buffers words for decode.
// Optional perf counters (stall/flush) are enabled with IFB_PERF_CNT_EN.
module ifetch_buffer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        rom_req_o,
  output logic [31:0] rom_addr_o,
  input  logic [31:0] rom_rdata_i,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o
`ifdef IFB_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int OW = AW + 2;

  logic [31:0]   pc;
  logic [31:0]   req_addr;
  logic [31:0]   last_addr;
  logic          inflight;
  logic [CW-1:0] count;
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [31:0]   mem_inst [DEPTH];
  logic [31:0]   mem_addr [DEPTH];
  logic          push;
  logic          pop;
  logic [OW-1:0] occ;
  logic [1:0]    unused_jaddr;

  assign unused_jaddr = jump_addr_i[1:0];

  assign inst_valid_o = (count != '0);
  assign pop          = inst_valid_o & inst_ready_i;
  assign push         = inflight & ~jump_en_i;

  // Occupancy counts the word already in flight so the FIFO never overflows.
  assign occ = OW'(count) + OW'(inflight) - OW'(pop);

  assign rom_addr_o = pc;
  assign rom_req_o  = rst & ~jump_en_i & (occ < OW'(DEPTH));

  assign inst_o      = inst_valid_o ? mem_inst[rptr] : NOP_INST;
  assign inst_addr_o = inst_valid_o ? mem_addr[rptr] : last_addr;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_inst[wptr] <= rom_rdata_i;
      mem_addr[wptr] <= req_addr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc        <= RESET_PC;
      req_addr  <= '0;
      last_addr <= '0;
      inflight  <= 1'b0;
      count     <= '0;
      wptr      <= '0;
      rptr      <= '0;
    end else begin
      if (inst_valid_o) begin
        last_addr <= mem_addr[rptr];
      end
      if (jump_en_i) begin
        pc       <= {jump_addr_i[31:2], 2'b00};
        inflight <= 1'b0;
        count    <= '0;
        wptr     <= '0;
        rptr     <= '0;
      end else begin
        inflight <= rom_req_o;
        if (rom_req_o) begin
          pc       <= pc + 32'd4;
          req_addr <= pc;
        end
        if (push) begin
          wptr <= wptr + AW'(1);
        end
        if (pop) begin
          rptr <= rptr + AW'(1);
        end
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

`ifdef IFB_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (!inst_valid_o && !jump_en_i) begin
        stall_cnt_o <= stall_cnt_o + 32'd1;
      end
      if (jump_en_i) begin
        flush_cnt_o <= flush_cnt_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ifetch_buffer.sv
// Directed bench for ifetch_buffer: streaming, stall, flush, jumps, async reset.
module tb_ifetch_buffer;

  logic        clk;
  logic        rst;
  logic        rom_req_o;
  logic [31:0] rom_addr_o;
  logic [31:0] rom_rdata_i;
  logic        jump_en_i;
  logic [31:0] jump_addr_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
`ifdef IFB_PERF_CNT_EN
  logic [31:0] stall_cnt_o;
  logic [31:0] flush_cnt_o;
`endif

  int checks = 0;
  int fails  = 0;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] BASE = 32'h0010_0093;

  ifetch_buffer dut (
    .clk          (clk),
    .rst          (rst),
    .rom_req_o    (rom_req_o),
    .rom_addr_o   (rom_addr_o),
    .rom_rdata_i  (rom_rdata_i),
    .jump_en_i    (jump_en_i),
    .jump_addr_i  (jump_addr_i),
    .inst_valid_o (inst_valid_o),
    .inst_ready_i (inst_ready_i),
    .inst_o       (inst_o),
    .inst_addr_o  (inst_addr_o)
`ifdef IFB_PERF_CNT_EN
    ,
    .stall_cnt_o  (stall_cnt_o),
    .flush_cnt_o  (flush_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read ROM: word n = BASE + n
  always @(posedge clk) begin
    if (rom_req_o) rom_rdata_i <= BASE + (rom_addr_o >> 2);
  end

  // Leaves time at cycle c0 (first cycle after release), outputs settled.
  task automatic do_reset();
    rst = 1'b0;
    jump_en_i = 1'b0;
    jump_addr_i = '0;
    inst_ready_i = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    jump_en_i = 1'b0;
    jump_addr_i = '0;
    inst_ready_i = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (rom_req_o !== 1'b0) begin
      fails++; $display("FAIL rst_req got=%b exp=0", rom_req_o);
    end
    checks++;
    if (inst_valid_o !== 1'b0) begin
      fails++; $display("FAIL rst_valid got=%b exp=0", inst_valid_o);
    end
    checks++;
    if (inst_o !== NOP) begin
      fails++; $display("FAIL rst_inst got=%h exp=%h", inst_o, NOP);
    end
    checks++;
    if (inst_addr_o !== 32'h0) begin
      fails++; $display("FAIL rst_addr got=%h exp=0", inst_addr_o);
    end
    checks++;
    if (rom_addr_o !== 32'h0) begin
      fails++; $display("FAIL rst_pc got=%h exp=0", rom_addr_o);
    end
  endtask

  task automatic test_stream();
    do_reset();
    for (int i = 0; i < 7; i++) begin
      if (i > 0) begin
        next_cycle();
        #1;
      end
      checks++;
      if (rom_req_o !== 1'b1 || rom_addr_o !== 32'(4 * i)) begin
        fails++;
        $display("FAIL stream_fetch c%0d got=%b/%h exp=1/%h",
                 i, rom_req_o, rom_addr_o, 32'(4 * i));
      end
      if (i < 2) begin
        checks++;
        if (inst_valid_o !== 1'b0) begin
          fails++; $display("FAIL stream_early_valid c%0d got=%b exp=0", i, inst_valid_o);
        end
      end else begin
        checks++;
        if (inst_valid_o !== 1'b1 || inst_o !== BASE + 32'(i - 2)
            || inst_addr_o !== 32'(4 * (i - 2))) begin
          fails++;
          $display("FAIL stream_inst c%0d got=%b/%h/%h exp=1/%h/%h", i,
                   inst_valid_o, inst_o, inst_addr_o,
                   BASE + 32'(i - 2), 32'(4 * (i - 2)));
        end
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    next_cycle();
    next_cycle();
    for (int i = 0; i < 5; i++) begin
      if (i > 0) next_cycle();
      inst_ready_i = 1'b0;
      #1;
      checks++;
      if (rom_req_o !== 1'b0 || inst_valid_o !== 1'b1
          || inst_addr_o !== 32'h0 || inst_o !== BASE) begin
        fails++;
        $display("FAIL stall_hold s%0d got=req%b v%b %h@%h exp=req0 v1 %h@0",
                 i, rom_req_o, inst_valid_o, inst_o, inst_addr_o, BASE);
      end
    end
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      inst_ready_i = 1'b1;
      #1;
      checks++;
      if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'(4 * i)
          || inst_o !== BASE + 32'(i)) begin
        fails++;
        $display("FAIL stall_release r%0d got=v%b %h@%h exp=v1 %h@%h", i,
                 inst_valid_o, inst_o, inst_addr_o, BASE + 32'(i), 32'(4 * i));
      end
    end
  endtask

  task automatic test_flush();
    do_reset();
    repeat (3) next_cycle();
    jump_en_i = 1'b1;
    jump_addr_i = 32'h40;
    #1;
    checks++;
    if (rom_req_o !== 1'b0) begin
      fails++; $display("FAIL flush_req_jump got=%b exp=0", rom_req_o);
    end
    next_cycle();
    jump_en_i = 1'b0;
    #1;
    checks++;
    if (inst_valid_o !== 1'b0 || inst_o !== NOP || inst_addr_o !== 32'h4) begin
      fails++;
      $display("FAIL flush_cleared got=v%b %h@%h exp=v0 %h@4",
               inst_valid_o, inst_o, inst_addr_o, NOP);
    end
    checks++;
    if (rom_req_o !== 1'b1 || rom_addr_o !== 32'h40) begin
      fails++; $display("FAIL flush_target got=%b/%h exp=1/40", rom_req_o, rom_addr_o);
    end
    next_cycle();
    #1;
    checks++;
    if (inst_valid_o !== 1'b0) begin
      fails++; $display("FAIL flush_stale got=%b exp=0", inst_valid_o);
    end
    next_cycle();
    #1;
    checks++;
    if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'h40 || inst_o !== BASE + 32'd16) begin
      fails++;
      $display("FAIL flush_first got=v%b %h@%h exp=v1 %h@40",
               inst_valid_o, inst_o, inst_addr_o, BASE + 32'd16);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    repeat (3) next_cycle();
    jump_en_i = 1'b1;
    jump_addr_i = 32'h43;
    next_cycle();
    jump_addr_i = 32'h80;
    #1;
    checks++;
    if (rom_addr_o !== 32'h40 || rom_req_o !== 1'b0) begin
      fails++; $display("FAIL misalign_pc got=%b/%h exp=0/40", rom_req_o, rom_addr_o);
    end
    next_cycle();
    jump_addr_i = 32'hC0;
    #1;
    checks++;
    if (rom_addr_o !== 32'h80 || rom_req_o !== 1'b0) begin
      fails++; $display("FAIL b2b_mid got=%b/%h exp=0/80", rom_req_o, rom_addr_o);
    end
    next_cycle();
    jump_en_i = 1'b0;
    #1;
    checks++;
    if (rom_addr_o !== 32'hC0 || rom_req_o !== 1'b1 || inst_valid_o !== 1'b0) begin
      fails++;
      $display("FAIL b2b_target got=%b/%h v%b exp=1/c0 v0",
               rom_req_o, rom_addr_o, inst_valid_o);
    end
    next_cycle();
    #1;
    checks++;
    if (inst_valid_o !== 1'b0) begin
      fails++; $display("FAIL b2b_gap got=%b exp=0", inst_valid_o);
    end
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      #1;
      checks++;
      if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'hC0 + 32'(4 * i)
          || inst_o !== BASE + 32'(48 + i)) begin
        fails++;
        $display("FAIL b2b_stream k%0d got=v%b %h@%h exp=v1 %h@%h", i,
                 inst_valid_o, inst_o, inst_addr_o,
                 BASE + 32'(48 + i), 32'hC0 + 32'(4 * i));
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    repeat (4) next_cycle();
    #3;
    rst = 1'b0;
    #1;
    checks++;
    if (inst_valid_o !== 1'b0 || rom_req_o !== 1'b0 || inst_o !== NOP
        || inst_addr_o !== 32'h0 || rom_addr_o !== 32'h0) begin
      fails++;
      $display("FAIL arst_now got=v%b req%b %h@%h pc%h exp=v0 req0 %h@0 pc0",
               inst_valid_o, rom_req_o, inst_o, inst_addr_o, rom_addr_o, NOP);
    end
    next_cycle();
    next_cycle();
    rst = 1'b1;
    #1;
    checks++;
    if (rom_req_o !== 1'b1 || rom_addr_o !== 32'h0 || inst_valid_o !== 1'b0) begin
      fails++;
      $display("FAIL arst_restart got=%b/%h v%b exp=1/0 v0",
               rom_req_o, rom_addr_o, inst_valid_o);
    end
    next_cycle();
    next_cycle();
    #1;
    checks++;
    if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'h0 || inst_o !== BASE) begin
      fails++;
      $display("FAIL arst_first got=v%b %h@%h exp=v1 %h@0",
               inst_valid_o, inst_o, inst_addr_o, BASE);
    end
  endtask

`ifdef IFB_PERF_CNT_EN
  task automatic test_perf();
    do_reset();
    checks++;
    if (stall_cnt_o !== 32'd0 || flush_cnt_o !== 32'd0) begin
      fails++; $display("FAIL perf_reset got=%0d/%0d exp=0/0", stall_cnt_o, flush_cnt_o);
    end
    repeat (3) next_cycle();
    jump_en_i = 1'b1;
    jump_addr_i = 32'h40;
    next_cycle();
    jump_en_i = 1'b0;
    next_cycle();
    #1;
    checks++;
    if (stall_cnt_o !== 32'd3 || flush_cnt_o !== 32'd1) begin
      fails++; $display("FAIL perf_counts got=%0d/%0d exp=3/1", stall_cnt_o, flush_cnt_o);
    end
  endtask
`endif

  initial begin
    rst = 1'b0;
    jump_en_i = 1'b0;
    jump_addr_i = '0;
    inst_ready_i = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_back_to_back();
    test_async_reset();
`ifdef IFB_PERF_CNT_EN
    test_perf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
